// File: rtl/fec_dec_ctrl.sv
// Frame sequencer for the 2-D parity FEC decoder: captures a frame,
// runs the decoder with a timeout, classifies and counts the result.
module fec_dec_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int START_LEN = 1,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  input  logic [DEPTH-1:0]       in_row_p,
  input  logic [WIDTH-1:0]       in_col_p,
  output logic                   dec_start,
  output logic [WIDTH*DEPTH-1:0] dec_data,
  output logic [DEPTH-1:0]       dec_row_p,
  output logic [WIDTH-1:0]       dec_col_p,
  input  logic                   dec_done,
  input  logic [WIDTH*DEPTH-1:0] dec_data_corr,
  input  logic                   dec_err_det,
  input  logic                   dec_err_corr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic [1:0]             out_status,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       cnt_clean,
  output logic [CNT_W-1:0]       cnt_corr,
  output logic [CNT_W-1:0]       cnt_uncorr,
  output logic [CNT_W-1:0]       cnt_tmo
);

  localparam int N  = WIDTH * DEPTH;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, START, WAIT, OUT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       slen_q, slen_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             done_prev_q;
  logic             in_ready_q, in_ready_d;
  logic             dec_start_q, dec_start_d;
  logic [N-1:0]     dec_data_q, dec_data_d;
  logic [DEPTH-1:0] dec_row_p_q, dec_row_p_d;
  logic [WIDTH-1:0] dec_col_p_q, dec_col_p_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [1:0]       out_status_q, out_status_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             done_edge;
  logic             cnt_inc;

  assign done_edge = dec_done & ~done_prev_q;
  assign cnt_inc   = (state_q == OUT) && out_ready;

  always_comb begin
    state_d      = state_q;
    slen_d       = slen_q;
    tmo_d        = tmo_q;
    in_ready_d   = in_ready_q;
    dec_start_d  = dec_start_q;
    dec_data_d   = dec_data_q;
    dec_row_p_d  = dec_row_p_q;
    dec_col_p_d  = dec_col_p_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          dec_data_d  = in_data;
          dec_row_p_d = in_row_p;
          dec_col_p_d = in_col_p;
          in_ready_d  = 1'b0;
          dec_start_d = 1'b1;
          slen_d      = '0;
          state_d     = START;
        end
      end
      START: begin
        if (slen_q == 4'(START_LEN - 1)) begin
          dec_start_d = 1'b0;
          tmo_d       = '0;
          state_d     = WAIT;
        end else begin
          slen_d = slen_q + 4'd1;
        end
      end
      WAIT: begin
        // A done edge outranks a timeout landing on the same cycle
        if (done_edge) begin
          out_valid_d = 1'b1;
          state_d     = OUT;
          unique case (1'b1)
            !dec_err_det: begin
              out_status_d = 2'b00;
              out_data_d   = dec_data_corr;
            end
            dec_err_det && dec_err_corr: begin
              out_status_d = 2'b01;
              out_data_d   = dec_data_corr;
            end
            default: begin
              out_status_d = 2'b10;
              out_data_d   = dec_data_q;
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          out_valid_d  = 1'b1;
          out_status_d = 2'b11;
          out_data_d   = dec_data_q;
          state_d      = OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (cnt_inc && out_status_q == 2'(i)
                   && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slen_q       <= '0;
      tmo_q        <= '0;
      done_prev_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      dec_start_q  <= 1'b0;
      dec_data_q   <= '0;
      dec_row_p_q  <= '0;
      dec_col_p_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slen_q       <= slen_d;
      tmo_q        <= tmo_d;
      done_prev_q  <= dec_done;
      in_ready_q   <= in_ready_d;
      dec_start_q  <= dec_start_d;
      dec_data_q   <= dec_data_d;
      dec_row_p_q  <= dec_row_p_d;
      dec_col_p_q  <= dec_col_p_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_ready   = in_ready_q;
  assign dec_start  = dec_start_q;
  assign dec_data   = dec_data_q;
  assign dec_row_p  = dec_row_p_q;
  assign dec_col_p  = dec_col_p_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;
  assign cnt_clean  = cnt_q[0];
  assign cnt_corr   = cnt_q[1];
  assign cnt_uncorr = cnt_q[2];
  assign cnt_tmo    = cnt_q[3];

endmodule

// File: tb/tb_fec_dec_ctrl.sv
// Bench for fec_dec_ctrl: stub 2-D parity decoder, vector table,
// result scoreboard and a saturating counter model.
module tb_fec_dec_ctrl;

  localparam int SL = 3;
  localparam int TO = 16;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_row_p, in_col_p;
  logic        dec_start;
  logic [15:0] dec_data;
  logic [3:0]  dec_row_p, dec_col_p;
  logic        dec_done;
  logic [15:0] dec_data_corr;
  logic        dec_err_det, dec_err_corr;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_status;
  logic        clr_cnt;
  logic [CW-1:0] cnt_clean, cnt_corr, cnt_uncorr, cnt_tmo;

  always #5 clk = ~clk;

  fec_dec_ctrl #(
    .WIDTH(4), .DEPTH(4), .START_LEN(SL), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_row_p(in_row_p), .in_col_p(in_col_p),
    .dec_start(dec_start), .dec_data(dec_data),
    .dec_row_p(dec_row_p), .dec_col_p(dec_col_p),
    .dec_done(dec_done), .dec_data_corr(dec_data_corr),
    .dec_err_det(dec_err_det), .dec_err_corr(dec_err_corr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status),
    .clr_cnt(clr_cnt),
    .cnt_clean(cnt_clean), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr), .cnt_tmo(cnt_tmo)
  );

  // mode 0: normal, 1: done never rises, 2: done stuck high
  int         dmode;
  logic       sp;
  logic [2:0] dly;

  function automatic logic [17:0] dmodel(input logic [15:0] d,
                                         input logic [3:0] rp,
                                         input logic [3:0] cp);
    logic [3:0]  rs, cs;
    logic [15:0] c;
    logic        det, cor;
    for (int i = 0; i < 4; i++) rs[i] = (^d[i*4 +: 4]) ^ rp[i];
    for (int j = 0; j < 4; j++)
      cs[j] = d[j] ^ d[4+j] ^ d[8+j] ^ d[12+j] ^ cp[j];
    c   = d;
    det = (|rs) || (|cs);
    cor = 1'b0;
    if ($countones(rs) == 1 && $countones(cs) == 1) begin
      cor = 1'b1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (rs[i] && cs[j]) c[i*4+j] = ~c[i*4+j];
    end
    return {det, cor, c};
  endfunction

  assign {dec_err_det, dec_err_corr, dec_data_corr} =
    dmodel(dec_data, dec_row_p, dec_col_p);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_done <= 1'b0;
      sp       <= 1'b0;
      dly      <= '0;
    end else begin
      sp <= dec_start;
      if (dec_start && !sp && dmode != 2) dec_done <= 1'b0;
      if (sp && !dec_start) begin
        dly <= 3'd3;
      end else if (dly != 0) begin
        dly <= dly - 3'd1;
        if (dly == 3'd1 && dmode == 0) dec_done <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  rp;
    logic [3:0]  cp;
    int          mode;
    logic [15:0] ed;
    logic [1:0]  es;
  } vec_t;

  vec_t        vt [8];
  logic [17:0] sb [$];
  int          ecnt [4];
  int          errs, checks;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk_cnts();
    chk("cnt_clean", cnt_clean, ecnt[0]);
    chk("cnt_corr", cnt_corr, ecnt[1]);
    chk("cnt_uncorr", cnt_uncorr, ecnt[2]);
    chk("cnt_tmo", cnt_tmo, ecnt[3]);
  endtask

  task automatic run_frame(input vec_t v, input int bp, input bit clr);
    int          n, sc, wc;
    logic        dd1, dd2;
    logic [15:0] hd;
    logic [1:0]  hs;
    logic [17:0] e;
    in_data  = v.d;
    in_row_p = v.rp;
    in_col_p = v.cp;
    dmode    = v.mode;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    sb.push_back({v.es, v.ed});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~v.d;
    sc = 0;
    while (dec_start && sc < 20) begin
      sc++;
      @(negedge clk);
    end
    chk("start_len", sc, SL);
    chk("dec_data_hold", dec_data, v.d);
    wc  = 0;
    dd1 = 1'b0;
    dd2 = 1'b0;
    while (!out_valid && wc < 200) begin
      dd2 = dd1;
      dd1 = dec_done;
      wc++;
      @(negedge clk);
    end
    chk("out_valid_wait", out_valid, 1);
    if (v.mode == 0) chk("done_to_valid", {dd2, dd1}, 2'b01);
    else chk("timeout_cycles", wc, TO);
    hd = out_data;
    hs = out_status;
    repeat (bp) @(negedge clk);
    if (bp > 0) begin
      chk("bp_hold", {out_valid, in_ready, out_status, out_data},
          {1'b1, 1'b0, hs, hd});
      chk_cnts();
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("out_status", out_status, e[17:16]);
    chk("out_data", out_data, e[15:0]);
    out_ready = 1'b1;
    clr_cnt   = clr;
    @(negedge clk);
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    if (clr) begin
      for (int i = 0; i < 4; i++) ecnt[i] = 0;
    end else if (ecnt[e[17:16]] < (1 << CW) - 1) begin
      ecnt[e[17:16]]++;
    end
    chk("out_valid_drop", out_valid, 0);
    chk_cnts();
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    dmode     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_row_p  = '0;
    in_col_p  = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    vt[0] = '{16'hFFFF, 4'h0, 4'h0, 0, 16'hFFFF, 2'b00};
    vt[1] = '{16'hFFFE, 4'h0, 4'h0, 0, 16'hFFFF, 2'b01};
    vt[2] = '{16'h7BDE, 4'h0, 4'h0, 0, 16'h7BDE, 2'b10};
    vt[3] = '{16'h1234, 4'h0, 4'h0, 1, 16'h1234, 2'b11};
    vt[4] = '{16'hA5A5, 4'h0, 4'h0, 0, 16'hA5A5, 2'b00};
    vt[5] = '{16'hA5E5, 4'h0, 4'h0, 0, 16'hA5A5, 2'b01};
    vt[6] = '{16'h0F0F, 4'h3, 4'h5, 2, 16'h0F0F, 2'b11};
    vt[7] = '{16'h0000, 4'h0, 4'h0, 0, 16'h0000, 2'b00};

    repeat (3) @(negedge clk);
    chk("rst_outs", {in_ready, out_valid, dec_start, out_status},
        '0);
    chk("rst_data", {out_data, dec_data}, '0);
    chk_cnts();
    rst_n = 1'b1;
    chk("rdy_at_release", in_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1);

    for (int i = 0; i < 8; i++) run_frame(vt[i], (i == 1) ? 10 : 0, 1'b0);

    // reset while the frame sits in WAIT
    in_data  = 16'h5555;
    dmode    = 1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (SL + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    chk("abort_outs", {in_ready, out_valid, dec_start, dec_data}, '0);
    chk_cnts();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {in_ready, out_valid}, 2'b10);

    run_frame(vt[0], 0, 1'b0);
    run_frame(vt[1], 0, 1'b1);

    for (int i = 0; i < 17; i++) run_frame(vt[4], 0, 1'b0);
    chk("sat_clean", cnt_clean, (1 << CW) - 1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
